mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control sequencer for the multicycle MIPS datapath. It is a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and write enable, including the ALU B-operand select that routes the shift-left-2 branch offset into the ALU. It stalls on a memory-ready handshake and flags unsupported opcodes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 6: IR[31:26], sampled in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by ALU zero (beq, and bne if enabled).
- `branch_ne` out 1: inverts the zero qualification (0 when BNE support is compiled out).
- `i_or_d` out 1: memory address source (0 = PC, 1 = ALUOut).
- `mem_read` / `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: register write data source (1 = MDR).
- `reg_dst` out 1: destination register (1 = rd).
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A operand (0 = PC, 1 = A).
- `alu_src_b` out 2: ALU B operand (00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2).
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9. Codes 10–15 go to FETCH on the next edge, with all outputs 0.
- Any output not listed for a state is 0.

**FETCH**
- Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
- ir_write = pc_write = mem_ready.
- Holds while mem_ready=0; goes to DECODE when mem_ready=1.

**DECODE**
- Outputs: alu_src_b=11, alu_op=00 (branch target PC+4+(imm<<2) into ALUOut).
- Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEM_ADDR.
  - 000000 → R_EXEC.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 for this cycle.

**Execute, memory and write-back states**
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.

**Control-transfer states**
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.

**Decode rule**
- opcode is decoded only in DECODE. Changes to opcode in any other state have no effect.

## Timing
- While rst_n=0: state=FETCH and every output is 0 (the FETCH decode is masked).
- Reset deassertion is sampled at the first rising edge; the FETCH outputs appear in the cycle after that edge.
- Reset asserted mid-instruction: state is forced to FETCH immediately and all outputs drop to 0 in the same cycle, with no clock needed. No partial write completes after reset.
- Latency with zero-wait memory (mem_ready held at 1):
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle; the strobes stay asserted throughout.
- mem_ready is ignored in all other states.
- ir_write and pc_write in FETCH are combinational in mem_ready and asserted for exactly one cycle.

## Configuration
- `MC_CTRL_BNE_EN` defined:
  - opcode 000101 → BRANCH.
  - branch_ne=1 during BRANCH when the decoded opcode was 000101. This requires a registered 1-bit flag captured in DECODE and cleared on reset.
- Undefined:
  - 000101 is illegal (illegal_op pulse, return to FETCH).
  - branch_ne is tied to 0.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → all outputs 0, state=0. Release rst_n → next cycle mem_read=1, alu_src_b=01, ir_write=1, pc_write=1.
- lw (100011), mem_ready=1 → state sequence 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1.
- sw with mem_ready low for 3 cycles in MEM_WRITE → mem_write=1 for 4 cycles, then state 0. Total 7 cycles.
- beq (000100) → DECODE shows alu_src_b=11. BRANCH shows pc_write_cond=1, alu_op=01, pc_source=01, branch_ne=0.
- opcode 111111 → illegal_op=1 for exactly one cycle in DECODE, then FETCH.
- With `MC_CTRL_BNE_EN`, opcode 000101 → BRANCH with branch_ne=1. Without the macro → illegal_op pulse.
- Assert rst_n=0 during MEM_READ → state=0 and mem_read=0 without a clock edge.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control sequencer for the multicycle MIPS datapath (Moore FSM, memory-ready stalls).
// Optional bne support is compiled in when MC_CTRL_BNE_EN is defined.
module mips_multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       branch_ne,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q, state_d;
   logic   run_q;
   logic   ld_q;
   logic   bne_dec;
   logic   bne_flag;

   // run_q holds outputs masked until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (state_q == S_DECODE)
            ld_q <= (opcode == OP_LW);
      end
   end

`ifdef MC_CTRL_BNE_EN
   logic bne_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bne_q <= 1'b0;
      else if (state_q == S_DECODE)
         bne_q <= (opcode == OP_BNE);
   end

   assign bne_dec  = (opcode == OP_BNE);
   assign bne_flag = bne_q;
`else
   assign bne_dec  = 1'b0;
   assign bne_flag = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      if (!run_q) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready)
                  state_d = S_DECODE;
            end
            S_DECODE: begin
               // Speculative branch target PC+4+(imm<<2) lands in ALUOut
               alu_src_b = 2'b11;
               if (opcode == OP_LW || opcode == OP_SW)
                  state_d = S_MEM_ADDR;
               else if (opcode == OP_RTYPE)
                  state_d = S_R_EXEC;
               else if (opcode == OP_BEQ || bne_dec)
                  state_d = S_BRANCH;
               else if (opcode == OP_J)
                  state_d = S_JUMP;
               else begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               state_d   = ld_q ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (mem_ready)
                  state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
               if (mem_ready)
                  state_d = S_FETCH;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               state_d   = S_R_WB;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               state_d   = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               branch_ne     = bne_flag;
               state_d       = S_FETCH;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control against an instruction-level reference model.
module tb_mips_multicycle_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
   logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   int n_chk = 0;
   int n_err = 0;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctl_t;

   ctl_t obs;
   assign obs = '{pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  illegal_op};

   mips_multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Instruction classes
   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4, K_J = 5, K_ILL = 6;

   function automatic int classify(input logic [5:0] op);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return K_R;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
`ifdef MC_CTRL_BNE_EN
         6'b000101: return K_BNE;
`endif
         default:   return K_ILL;
      endcase
   endfunction

   // Expected control word for a given step of an instruction
   function automatic ctl_t expv(input int st, input logic mr, input logic ill, input logic bne);
      ctl_t c;
      c = '0;
      case (st)
         0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
         1: begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
         2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         3: begin c.mem_read = 1; c.i_or_d = 1; end
         4: begin c.reg_write = 1; c.mem_to_reg = 1; end
         5: begin c.mem_write = 1; c.i_or_d = 1; end
         6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         7: begin c.reg_write = 1; c.reg_dst = 1; end
         8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                  c.pc_source = 2'b01; c.branch_ne = bne; end
         9: begin c.pc_write = 1; c.pc_source = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   int cyc_cnt;

   // One clock cycle: drive inputs just after the edge, check at the falling edge
   task automatic cyc(input int st, input logic mr, input logic [5:0] op, input logic ill,
                      input logic bne);
      mem_ready = mr;
      opcode    = op;
      @(negedge clk);
      chk($sformatf("state_s%0d", st), 32'(state), 32'(st));
      chk($sformatf("ctl_s%0d", st), 32'(obs), 32'(expv(st, mr, ill, bne)));
      cyc_cnt++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      int k;
      k = classify(op);
      cyc_cnt = 0;
      for (int i = 0; i < wf; i++) cyc(0, 1'b0, rop(), 1'b0, 1'b0);
      cyc(0, 1'b1, rop(), 1'b0, 1'b0);
      cyc(1, rb(), op, k == K_ILL, 1'b0);
      case (k)
         K_LW: begin
            cyc(2, rb(), rop(), 1'b0, 1'b0);
            for (int i = 0; i < wm; i++) cyc(3, 1'b0, rop(), 1'b0, 1'b0);
            cyc(3, 1'b1, rop(), 1'b0, 1'b0);
            cyc(4, rb(), rop(), 1'b0, 1'b0);
         end
         K_SW: begin
            cyc(2, rb(), rop(), 1'b0, 1'b0);
            for (int i = 0; i < wm; i++) cyc(5, 1'b0, rop(), 1'b0, 1'b0);
            cyc(5, 1'b1, rop(), 1'b0, 1'b0);
         end
         K_R: begin
            cyc(6, rb(), rop(), 1'b0, 1'b0);
            cyc(7, rb(), rop(), 1'b0, 1'b0);
         end
         K_BEQ: cyc(8, rb(), rop(), 1'b0, 1'b0);
         K_BNE: cyc(8, rb(), rop(), 1'b0, 1'b1);
         K_J:   cyc(9, rb(), rop(), 1'b0, 1'b0);
         default: ;
      endcase
   endtask

   logic [5:0] op_tab [6];

   initial begin
      op_tab[0] = 6'b100011; op_tab[1] = 6'b101011; op_tab[2] = 6'b000000;
      op_tab[3] = 6'b000100; op_tab[4] = 6'b000010; op_tab[5] = 6'b000101;

      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'b100011;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctl", 32'(obs), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_masked", 32'(obs), 32'd0);
      @(posedge clk);
      #1;

      // lw, sw with three wait cycles, beq, illegal, bne
      run_instr(6'b100011, 0, 0);
      chk("lw_latency", 32'(cyc_cnt), 32'd5);
      run_instr(6'b101011, 0, 3);
      chk("sw_wait_latency", 32'(cyc_cnt), 32'd7);
      run_instr(6'b000100, 0, 0);
      chk("beq_latency", 32'(cyc_cnt), 32'd3);
      run_instr(6'b111111, 0, 0);
      chk("ill_latency", 32'(cyc_cnt), 32'd2);
      run_instr(6'b000101, 1, 0);
      run_instr(6'b000000, 2, 0);
      run_instr(6'b000010, 0, 0);

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         int sel;
         sel = $urandom_range(0, 7);
         op  = (sel < 6) ? op_tab[sel] : rop();
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Asynchronous reset in the middle of a stalled lw read
      cyc(0, 1'b1, rop(), 1'b0, 1'b0);
      cyc(1, 1'b1, 6'b100011, 1'b0, 1'b0);
      cyc(2, 1'b1, rop(), 1'b0, 1'b0);
      mem_ready = 1'b0;
      #2;
      chk("mid_state_pre", 32'(state), 32'd3);
      chk("mid_rd_pre", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_state_rst", 32'(state), 32'd0);
      chk("mid_rd_rst", 32'(mem_read), 32'd0);
      chk("mid_ctl_rst", 32'(obs), 32'd0);
      mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_ctl_rst", 32'(obs), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_instr(6'b000000, 0, 0);
      run_instr(6'b100011, 1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
